// File: rtl/time_frame_pkg.sv
// Shared constants and state encoding for the ASCII time-frame parser.
package time_frame_pkg;

  localparam logic [7:0] CH_T     = 8'h54;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;

  typedef enum logic [3:0] {
    IDLE,
    H1,
    H0,
    C1,
    M1,
    M0,
    C2,
    S1,
    S0,
    EOL
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/ascii_pair_to_bin.sv
// Tens/units BCD digit pair to 7-bit binary, with a range flag.
module ascii_pair_to_bin (
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       in_range
);

  logic [6:0] t7;

  assign t7       = {3'b000, tens};
  assign value    = (t7 << 3) + (t7 << 1) + {3'b000, units};
  assign in_range = (value <= limit);

endmodule

// File: rtl/time_frame_parser.sv
// Parses "THH:MM:SS<CR|LF>" into binary time with a synced level.
// Optional inter-byte timeout enabled by defining TFP_TIMEOUT_EN.
module time_frame_parser
  import time_frame_pkg::*;
#(
  parameter int CLK_FREQ       = 50000000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       synced,
  output logic       frame_err
);

  state_t state;

  logic [3:0] h1_q, h0_q;
  logic [3:0] m1_q, m0_q;
  logic [3:0] s1_q, s0_q;

  logic [6:0] hv, mv, sv;
  logic       h_ok, m_ok, s_ok;

  logic       is_t, is_dig, is_col, is_eol;
  logic       byte_ok;
  logic [3:0] digit;

  ascii_pair_to_bin u_hour (
    .tens     (h1_q),
    .units    (h0_q),
    .limit    (7'(MAX_HOUR)),
    .value    (hv),
    .in_range (h_ok)
  );

  ascii_pair_to_bin u_min (
    .tens     (m1_q),
    .units    (m0_q),
    .limit    (7'(MAX_MIN)),
    .value    (mv),
    .in_range (m_ok)
  );

  ascii_pair_to_bin u_sec (
    .tens     (s1_q),
    .units    (s0_q),
    .limit    (7'(MAX_SEC)),
    .value    (sv),
    .in_range (s_ok)
  );

  wire unused_hi = ^{hv[6:5], mv[6], sv[6]};

  assign is_t   = (rx_data == CH_T);
  assign is_dig = is_digit(rx_data);
  assign is_col = (rx_data == CH_COLON);
  assign is_eol = (rx_data == CH_CR) || (rx_data == CH_LF);
  assign digit  = 4'(rx_data - CH_0);

  // EOL only counts as good when the whole time is in range
  always_comb begin
    byte_ok = 1'b0;
    unique case (state)
      H1, H0, M1, M0, S1, S0: byte_ok = is_dig;
      C1, C2:                 byte_ok = is_col;
      EOL:                    byte_ok = is_eol && h_ok && m_ok && s_ok;
      default:                byte_ok = 1'b0;
    endcase
  end

`ifdef TFP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] gap_cnt;
  logic          gap_hit;

  assign gap_hit = (state != IDLE) && !rx_valid &&
                   (gap_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == IDLE || rx_valid || gap_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end
`else
  wire unused_timeout = |TIMEOUT_CYCLES;
  logic gap_hit;
  assign gap_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      h1_q      <= '0;
      h0_q      <= '0;
      m1_q      <= '0;
      m0_q      <= '0;
      s1_q      <= '0;
      s0_q      <= '0;
      hour_out  <= '0;
      min_out   <= '0;
      sec_out   <= '0;
      synced    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (gap_hit) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end else if (rx_valid) begin
        if (state == IDLE) begin
          if (is_t) begin
            state  <= H1;
            synced <= 1'b0;
          end
        end else if (!byte_ok) begin
          // a stray 'T' starts a fresh frame rather than being lost
          frame_err <= 1'b1;
          state     <= is_t ? H1 : IDLE;
        end else begin
          unique case (state)
            H1: begin h1_q <= digit; state <= H0; end
            H0: begin h0_q <= digit; state <= C1; end
            C1: state <= M1;
            M1: begin m1_q <= digit; state <= M0; end
            M0: begin m0_q <= digit; state <= C2; end
            C2: state <= S1;
            S1: begin s1_q <= digit; state <= S0; end
            S0: begin s0_q <= digit; state <= EOL; end
            EOL: begin
              hour_out <= hv[4:0];
              min_out  <= mv[5:0];
              sec_out  <= sv[5:0];
              synced   <= 1'b1;
              state    <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_time_frame_parser.sv
// Randomized bench for time_frame_parser against a frame-level model.
module tb_time_frame_parser;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] hour_out;
  logic [5:0] min_out;
  logic [5:0] sec_out;
  logic       synced;
  logic       frame_err;

  int n_chk = 0;
  int n_err = 0;

  // model state: frame text collected after 'T'
  bit         m_in;
  logic [7:0] m_buf[$];
  int         m_h, m_m, m_s;
  bit         m_sync, m_err;
  int         m_gap;
  string      pat = "DD:DD:DDE";

  time_frame_parser #(
    .CLK_FREQ       (1000),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .hour_out  (hour_out),
    .min_out   (min_out),
    .sec_out   (sec_out),
    .synced    (synced),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit cls_ok(input byte c, input logic [7:0] b);
    case (c)
      "D":     return b >= 8'h30 && b <= 8'h39;
      ":":     return b == 8'h3A;
      default: return b == 8'h0D || b == 8'h0A;
    endcase
  endfunction

  function automatic int pair(input int i);
    return (int'(m_buf[i]) - 48) * 10 + (int'(m_buf[i+1]) - 48);
  endfunction

  task automatic m_reject(input logic [7:0] b);
    m_err = 1;
    if (b == 8'h54) m_buf.delete();
    else m_in = 0;
  endtask

  task automatic model(input bit r, input bit v, input logic [7:0] b);
    int i, h, mi, s;
    m_err = 0;
    if (r) begin
      m_in = 0; m_buf.delete();
      m_h = 0; m_m = 0; m_s = 0;
      m_sync = 0; m_gap = 0;
    end else if (v) begin
      m_gap = 0;
      if (!m_in) begin
        if (b == 8'h54) begin
          m_in = 1; m_buf.delete(); m_sync = 0;
        end
      end else begin
        i = m_buf.size();
        if (!cls_ok(pat[i], b)) m_reject(b);
        else if (i < 8) m_buf.push_back(b);
        else begin
          h = pair(0); mi = pair(3); s = pair(6);
          if (h <= 23 && mi <= 59 && s <= 59) begin
            m_h = h; m_m = mi; m_s = s;
            m_sync = 1; m_in = 0;
          end else m_reject(b);
        end
      end
    end
`ifdef TFP_TIMEOUT_EN
    else if (m_in) begin
      if (m_gap == TO - 1) begin
        m_err = 1; m_in = 0; m_gap = 0;
      end else m_gap++;
    end
`endif
  endtask

  task automatic cyc(input bit r, input bit v, input logic [7:0] b);
    rst = r; rx_valid = v; rx_data = b;
    model(r, v, b);
    @(negedge clk);
    chk("hour", int'(hour_out), m_h);
    chk("min", int'(min_out), m_m);
    chk("sec", int'(sec_out), m_s);
    chk("synced", int'(synced), int'(m_sync));
    chk("frame_err", int'(frame_err), int'(m_err));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 8'($urandom));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cyc(0, 1, s[i]);
  endtask

  task automatic push2(inout logic [7:0] q[$], input int v);
    q.push_back(8'(48 + v / 10));
    q.push_back(8'(48 + v % 10));
  endtask

  task automatic rand_frame();
    logic [7:0] q[$];
    int k, h, mi, s;
    k  = $urandom_range(0, 11);
    h  = $urandom_range(0, 23);
    mi = $urandom_range(0, 59);
    s  = $urandom_range(0, 59);
    if (k == 0) h  = $urandom_range(24, 99);
    if (k == 1) mi = $urandom_range(60, 99);
    if (k == 2) s  = $urandom_range(60, 99);
    if (k == 5) repeat ($urandom_range(1, 4)) q.push_back(8'($urandom));
    q.push_back(8'h54);
    push2(q, h);  q.push_back(8'h3A);
    push2(q, mi); q.push_back(8'h3A);
    push2(q, s);
    q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
    if (k == 3) q[$urandom_range(1, 9)] = 8'($urandom);
    if (k == 4) q = q[0:$urandom_range(1, 8)];
    foreach (q[i]) begin
      cyc(0, 1, q[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    cyc(1, 0, 8'h00);
    cyc(1, 1, 8'h54);
    chk("rst_synced", int'(synced), 0);
    chk("rst_hour", int'(hour_out), 0);
    idle(2);

    send_str("T12:34:56\n");
    chk("t1_hour", int'(hour_out), 12);
    chk("t1_min", int'(min_out), 34);
    chk("t1_sec", int'(sec_out), 56);
    chk("t1_synced", int'(synced), 1);
    idle(2);

    send_str("T24:00:00\r");
    chk("t2_err", int'(frame_err), 1);
    chk("t2_hold", int'(hour_out), 12);
    chk("t2_synced", int'(synced), 0);
    idle(2);

    send_str("T12:3T08:15:30\n");
    chk("t3_hour", int'(hour_out), 8);
    chk("t3_sec", int'(sec_out), 30);
    idle(1);

    send_str("T23:59:59\n");
    send_str("T");
    chk("t4_drop", int'(synced), 0);
    send_str("00:00:00\n");
    chk("t4_hour", int'(hour_out), 0);
    chk("t4_synced", int'(synced), 1);

    send_str("T1");
    cyc(1, 1, 8'h30);
    chk("t5_synced", int'(synced), 0);
    send_str("T05:06:07\n");
    chk("t5_min", int'(min_out), 6);

`ifdef TFP_TIMEOUT_EN
    send_str("T12:");
    idle(TO + 2);
    send_str("34:56\n");
    chk("t6_synced", int'(synced), 0);
    chk("t6_min", int'(min_out), 6);
`endif

    repeat (200) begin
      rand_frame();
      if ($urandom_range(0, 40) == 0) cyc(1, 0, 8'h00);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
